// File: rtl/mult_writeback_pkg.sv
// Shared multiplier definitions: widths, the stage bundle handed to the tail
// stage, and the sign/zero fix-up applied to the unsigned magnitude product.
package mult_writeback_pkg;

  localparam int MULT_DATA_W = 32;
  localparam int REGDEST_W   = 5;
  localparam int SIGN_W      = 128;

  typedef struct packed {
    logic                     oper;
    logic [2*MULT_DATA_W-1:0] product;
    logic [REGDEST_W-1:0]     regdest;
    logic                     ispositive;
    logic                     iszero;
  } mult_stage_t;

  // Works at SIGN_W so any product width up to SIGN_W can truncate the result;
  // negation modulo 2^SIGN_W truncates to negation modulo the narrower width.
  function automatic logic [SIGN_W-1:0] apply_sign(input logic [SIGN_W-1:0] product,
                                                   input logic              ispositive,
                                                   input logic              iszero);
    logic [SIGN_W-1:0] result;
    if (iszero) begin
      result = {SIGN_W{1'b0}};
    end else if (ispositive) begin
      result = product;
    end else begin
      result = ~product + SIGN_W'(1);
    end
    return result;
  endfunction

endpackage

// File: rtl/mult_result_fifo.sv
// Generic synchronous FIFO with occupancy count; storage is not reset, only
// the pointers and count are.
module mult_result_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 69
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         i_push,
  input  logic                         i_pop,
  input  logic [WIDTH-1:0]             i_data,
  output logic [WIDTH-1:0]             o_data,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic                         o_full,
  output logic                         o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == CNT_W'(0));
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];

  // Entry storage write.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= PTR_W'(0);
      r_rd_ptr <= PTR_W'(0);
      r_count  <= CNT_W'(0);
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mult_writeback.sv
// Multiplier tail stage: signs the magnitude product, buffers results and
// drains them to the register-file writeback port under valid/ready.
module mult_writeback
  import mult_writeback_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int DATA_W = MULT_DATA_W
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  m2_m3_oper,
  input  logic [2*DATA_W-1:0]   m2_m3_product,
  input  logic [REGDEST_W-1:0]  m2_m3_regdest,
  input  logic                  m2_m3_ispositive,
  input  logic                  m2_m3_iszero,
  input  logic                  wb_ready,
  output logic                  m3_stall,
  output logic                  m3_wb_oper,
  output logic [REGDEST_W-1:0]  m3_wb_regdest,
  output logic [DATA_W-1:0]     m3_wb_result_lo,
  output logic [DATA_W-1:0]     m3_wb_result_hi
);

  localparam int PROD_W  = 2*DATA_W;
  localparam int ENTRY_W = REGDEST_W + PROD_W;
  localparam int CNT_W   = $clog2(DEPTH+1);

  logic [PROD_W-1:0]  w_result;
  logic               w_push;
  logic               w_pop;
  logic [ENTRY_W-1:0] w_head;
  logic [ENTRY_W-1:0] w_head_vis;
  logic [CNT_W-1:0]   w_count;
  logic               w_full;
  logic               w_empty;

  assign w_result = PROD_W'(apply_sign(SIGN_W'(m2_m3_product), m2_m3_ispositive, m2_m3_iszero));

  // Writes to r0 are swallowed here so they never occupy a buffer slot.
  assign w_push = m2_m3_oper && !m3_stall && (m2_m3_regdest != REGDEST_W'(0));
  assign w_pop  = m3_wb_oper && wb_ready;

  mult_result_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  ({m2_m3_regdest, w_result}),
    .o_data  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Stall and valid come straight from the registered count, so wb_ready
  // never reaches m3_stall combinationally.
  assign m3_stall   = w_full;
  assign m3_wb_oper = (w_count != CNT_W'(0));
  assign w_head_vis = w_empty ? {ENTRY_W{1'b0}} : w_head;

  assign m3_wb_regdest   = w_head_vis[ENTRY_W-1:PROD_W];
  assign m3_wb_result_hi = w_head_vis[PROD_W-1:DATA_W];
  assign m3_wb_result_lo = w_head_vis[DATA_W-1:0];

endmodule

// File: tb/tb_mult_writeback.sv
// Directed bench for mult_writeback with a result scoreboard queue.
module tb_mult_writeback;
  import mult_writeback_pkg::*;

  localparam int DEPTH  = 2;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic [4:0]  rd;
    logic [63:0] res;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  mult_stage_t stim;
  logic        wb_ready;
  logic        m3_stall;
  logic        m3_wb_oper;
  logic [4:0]  m3_wb_regdest;
  logic [31:0] m3_wb_result_lo;
  logic [31:0] m3_wb_result_hi;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clock = ~clock;

  mult_writeback #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clock            (clock),
    .reset            (reset),
    .m2_m3_oper       (stim.oper),
    .m2_m3_product    (stim.product),
    .m2_m3_regdest    (stim.regdest),
    .m2_m3_ispositive (stim.ispositive),
    .m2_m3_iszero     (stim.iszero),
    .wb_ready         (wb_ready),
    .m3_stall         (m3_stall),
    .m3_wb_oper       (m3_wb_oper),
    .m3_wb_regdest    (m3_wb_regdest),
    .m3_wb_result_lo  (m3_wb_result_lo),
    .m3_wb_result_hi  (m3_wb_result_hi)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_result(input logic [63:0] p, input logic pos, input logic z);
    if (z) return 64'd0;
    if (pos) return p;
    return 64'd0 - p;
  endfunction

  // Check current outputs against the scoreboard, update it for the coming edge, then advance.
  task automatic cycle();
    bit push_pred;
    chk("oper", m3_wb_oper, q.size() != 0);
    chk("stall", m3_stall, q.size() == DEPTH);
    if (q.size() != 0) begin
      chk("head_regdest", m3_wb_regdest, q[0].rd);
      chk("head_lo", m3_wb_result_lo, q[0].res[31:0]);
      chk("head_hi", m3_wb_result_hi, q[0].res[63:32]);
    end else begin
      chk("idle_regdest", m3_wb_regdest, 64'd0);
      chk("idle_lo", m3_wb_result_lo, 64'd0);
      chk("idle_hi", m3_wb_result_hi, 64'd0);
    end
    push_pred = stim.oper && (q.size() != DEPTH) && (stim.regdest != 5'd0);
    if (wb_ready && q.size() != 0) void'(q.pop_front());
    if (push_pred) q.push_back('{stim.regdest, ref_result(stim.product, stim.ispositive, stim.iszero)});
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [63:0] p, input logic [4:0] rd, input logic pos, input logic z);
    stim.oper       = 1'b1;
    stim.product    = p;
    stim.regdest    = rd;
    stim.ispositive = pos;
    stim.iszero     = z;
  endtask

  initial begin
    reset    = 1'b0;
    stim     = '0;
    wb_ready = 1'b1;
    @(posedge clock); #1;
    chk("rst_oper", m3_wb_oper, 64'd0);
    chk("rst_stall", m3_stall, 64'd0);
    chk("rst_regdest", m3_wb_regdest, 64'd0);
    chk("rst_lo", m3_wb_result_lo, 64'd0);
    chk("rst_hi", m3_wb_result_hi, 64'd0);
    reset = 1'b1;
    @(posedge clock); #1;

    // Signed results through an empty buffer
    drive(64'd15, 5'd3, 1'b1, 1'b0);
    cycle();
    stim.oper = 1'b0;
    chk("pos_oper", m3_wb_oper, 64'd1);
    chk("pos_lo", m3_wb_result_lo, 64'h0000_000F);
    chk("pos_hi", m3_wb_result_hi, 64'd0);
    chk("pos_regdest", m3_wb_regdest, 64'd3);
    cycle();
    drive(64'd15, 5'd5, 1'b0, 1'b0);
    cycle();
    stim.oper = 1'b0;
    chk("neg_lo", m3_wb_result_lo, 64'hFFFF_FFF1);
    chk("neg_hi", m3_wb_result_hi, 64'hFFFF_FFFF);
    cycle();
    drive(64'h1234, 5'd6, 1'b0, 1'b1);
    cycle();
    stim.oper = 1'b0;
    chk("zero_oper", m3_wb_oper, 64'd1);
    chk("zero_lo", m3_wb_result_lo, 64'd0);
    chk("zero_hi", m3_wb_result_hi, 64'd0);
    cycle();
    cycle();

    // Fill, stall, hold a third operation, then drain in order
    wb_ready = 1'b0;
    drive(64'd7, 5'd1, 1'b1, 1'b0);
    cycle();
    drive(64'd9, 5'd2, 1'b0, 1'b0);
    cycle();
    chk("full_stall", m3_stall, 64'd1);
    drive(64'd100, 5'd4, 1'b1, 1'b0);
    cycle();
    cycle();
    chk("held_head", m3_wb_regdest, 64'd1);
    chk("held_stall", m3_stall, 64'd1);
    wb_ready = 1'b1;
    cycle();
    chk("stall_drop", m3_stall, 64'd0);
    chk("second_head", m3_wb_regdest, 64'd2);
    cycle();
    stim.oper = 1'b0;
    chk("third_head", m3_wb_regdest, 64'd4);
    chk("third_lo", m3_wb_result_lo, 64'd100);
    cycle();
    chk("drained", m3_wb_oper, 64'd0);

    // Simultaneous push and pop with one entry buffered
    wb_ready = 1'b0;
    drive(64'd21, 5'd7, 1'b1, 1'b0);
    cycle();
    wb_ready = 1'b1;
    drive(64'h1_0000_0002, 5'd8, 1'b0, 1'b0);
    cycle();
    stim.oper = 1'b0;
    chk("pp_oper", m3_wb_oper, 64'd1);
    chk("pp_stall", m3_stall, 64'd0);
    chk("pp_regdest", m3_wb_regdest, 64'd8);
    chk("pp_lo", m3_wb_result_lo, 64'hFFFF_FFFE);
    chk("pp_hi", m3_wb_result_hi, 64'hFFFF_FFFE);
    cycle();
    chk("pp_empty", m3_wb_oper, 64'd0);

    // Destination r0 is discarded
    drive(64'd55, 5'd0, 1'b1, 1'b0);
    cycle();
    stim.oper = 1'b0;
    chk("r0_oper", m3_wb_oper, 64'd0);
    cycle();
    chk("r0_oper_later", m3_wb_oper, 64'd0);

    // Reset with two entries buffered
    wb_ready = 1'b0;
    drive(64'd3, 5'd9, 1'b1, 1'b0);
    cycle();
    drive(64'd4, 5'd10, 1'b1, 1'b0);
    cycle();
    stim.oper = 1'b0;
    chk("prerst_stall", m3_stall, 64'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_oper", m3_wb_oper, 64'd0);
    chk("mid_rst_stall", m3_stall, 64'd0);
    chk("mid_rst_regdest", m3_wb_regdest, 64'd0);
    chk("mid_rst_lo", m3_wb_result_lo, 64'd0);
    chk("mid_rst_hi", m3_wb_result_hi, 64'd0);
    q.delete();
    @(posedge clock); #1;
    reset    = 1'b1;
    wb_ready = 1'b1;
    repeat (3) cycle();
    chk("post_rst_idle", m3_wb_oper, 64'd0);
    drive(64'd77, 5'd11, 1'b1, 1'b0);
    cycle();
    stim.oper = 1'b0;
    chk("post_rst_push", m3_wb_regdest, 64'd11);
    cycle();
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mult_writeback.md
Name: mult_writeback

Overview:
- Tail stage of the multiplier pipeline: the consumer of the flag/operand convention that the multiplier's entry stage produces.
- Receives the unsigned 64-bit magnitude product from the preceding stage, together with the ispositive/iszero flags and the destination register.
- Applies the sign and the zero override, and buffers results in a small FIFO.
- Drains results to the shared register-file writeback port under a valid/ready handshake; asserts stall upstream when full.

Parameters:
- DEPTH, 2, number of result buffer entries (power of two, >=2).
- DATA_W, 32, register width; product width is 2*DATA_W.

Ports:
- clock  input  1  pipeline clock.
- reset  input  1  asynchronous, active-low reset.
- m2_m3_oper  input  1  valid multiply result presented this cycle.
- m2_m3_product  input  2*DATA_W  unsigned magnitude product.
- m2_m3_regdest  input  5  destination register.
- m2_m3_ispositive  input  1  1 = result non-negative.
- m2_m3_iszero  input  1  1 = an operand was zero.
- wb_ready  input  1  writeback port accepts this cycle.
- m3_stall  output  1  buffer full; upstream must hold its stage.
- m3_wb_oper  output  1  valid result at the writeback port.
- m3_wb_regdest  output  5  destination of head entry.
- m3_wb_result_lo  output  DATA_W  low half of signed product.
- m3_wb_result_hi  output  DATA_W  high half of signed product.

Behaviour:
- Reset (async, reset=0):
  - count=0, read/write pointers=0.
  - m3_wb_oper=0, m3_stall=0.
  - m3_wb_regdest=0, m3_wb_result_lo=0, m3_wb_result_hi=0.
  - Storage contents are don't-care, but outputs must read 0 while empty.
- Result formation (combinational, before enqueue):
  - iszero=1 -> 0, regardless of product and ispositive.
  - else ispositive=1 -> product.
  - else -> two's-complement negation of product, full 2*DATA_W width; magnitude 0 negates to 0.
- Enqueue:
  - push = m2_m3_oper && !m3_stall && (m2_m3_regdest != 0).
  - regdest 0 entries are consumed and discarded: no enqueue, no stall effect.
- Dequeue: pop = m3_wb_oper && wb_ready; head advances at the clock edge.
- m3_stall = (count == DEPTH), driven from the registered count only, with no combinational path from wb_ready.
  - With m3_stall=1, m2_m3_oper is ignored; upstream holds its registers.
- Simultaneous push and pop: the push is only possible when not full.
  - count is unchanged, both pointers advance.
  - When count==1, the pushed entry becomes the head on the next cycle.
- Latency: a result accepted at edge N appears on m3_wb_* after edge N when the buffer was empty (1 cycle). Otherwise it follows FIFO order.
- Outputs:
  - m3_wb_oper = (count != 0).
  - m3_wb_regdest/result_* reflect the head entry while oper=1 and are forced to 0 while empty.
  - All outputs hold steady while m3_wb_oper=1 and wb_ready=0.
- Pointers wrap modulo DEPTH; count ranges 0..DEPTH.
- Reset mid-operation flushes all buffered entries; nothing is written back afterwards.

Decomposition:
- Shared mult package:
  - DATA_W default.
  - REGDEST_W=5.
  - Struct for the stage bundle {oper, product, regdest, ispositive, iszero}.
  - Function apply_sign(product, ispositive, iszero).
- One natural sub-module: mult_result_fifo, a generic DEPTH x (5+2*DATA_W) synchronous FIFO with count, full and empty.

Test Plan:
- Signed cases with empty buffer and wb_ready=1:
  - product=15, ispositive=1, iszero=0, regdest=3 -> next cycle oper=1, lo=0x0000000F, hi=0, regdest=3.
  - product=15, ispositive=0 -> lo=0xFFFFFFF1, hi=0xFFFFFFFF.
  - iszero=1 with product=0x1234, ispositive=0 -> lo=0, hi=0.
- Full and stall: wb_ready=0; push regdest 1,2 -> m3_stall=1 after the second push; a third oper (regdest 4) is held by upstream and not accepted. Raise wb_ready -> outputs regdest 1, 2, then 4 in order, and m3_stall drops the cycle after the first pop.
- Simultaneous push/pop at count=1: count stays 1, and the next head is the new entry with correct value.
- regdest=0 with oper=1 -> no m3_wb_oper pulse, count unchanged.
- Reset asserted while count=2 -> outputs all 0 immediately. After release, no writeback occurs until a new push.
